// File: rtl/wic_int_cond.sv
// Interrupt source conditioner: synchronises 32 raw lines into wic_clk, glitch-filters them,
// and presents level or latched rising-edge requests cleared by the vectored-interrupt ack.
module wic_int_cond #(
  parameter int unsigned FILT_W = 4
) (
  input  logic              wic_clk,
  input  logic              pad_cpu_rst_b,
  input  logic [31:0]       pad_int_src,
  input  logic [31:0]       int_edge_mode,
  input  logic [31:0]       int_filt_en,
  input  logic [FILT_W-1:0] filt_cyc,
  input  logic [31:0]       biu_pad_psr,
  output logic [31:0]       pad_wic_int_vld,
  output logic [31:0]       int_src_stat
);

  logic [31:0]       s1;
  logic [31:0]       s2;
  logic [31:0]       filt_q;
  logic [31:0]       edge_lat;
  logic [31:0]       ack_ff;
  logic [31:0]       ack_clr;
  logic [31:0]       ack_pulse;
  logic [31:0]       upd;
  logic [31:0]       rise;
  logic [FILT_W-1:0] cnt [32];
  logic [FILT_W-1:0] thr_m1;

  // A threshold of 0 behaves like 1, so the terminal count is never below zero
  assign thr_m1 = (filt_cyc == '0) ? '0 : filt_cyc - FILT_W'(1);

  always_comb begin
    ack_clr = '0;
    if (biu_pad_psr[23:21] == 3'b001)
      ack_clr[biu_pad_psr[20:16]] = 1'b1;
  end

  assign ack_pulse = ack_clr & ~ack_ff;

  always_comb begin
    upd = '0;
    for (int unsigned i = 0; i < 32; i++)
      upd[i] = (s2[i] != filt_q[i]) && (!int_filt_en[i] || (cnt[i] >= thr_m1));
  end

  assign rise = upd & s2;

  always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      s1       <= '0;
      s2       <= '0;
      filt_q   <= '0;
      edge_lat <= '0;
      ack_ff   <= '0;
      for (int unsigned i = 0; i < 32; i++)
        cnt[i] <= '0;
    end else begin
      s1     <= pad_int_src;
      s2     <= s1;
      ack_ff <= ack_clr;
      for (int unsigned i = 0; i < 32; i++) begin
        if (!int_filt_en[i]) begin
          filt_q[i] <= s2[i];
          cnt[i]    <= '0;
        end else if (s2[i] == filt_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= thr_m1) begin
          filt_q[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + FILT_W'(1);
        end

        // A new edge takes priority over a coincident acknowledge
        if (!int_edge_mode[i])
          edge_lat[i] <= 1'b0;
        else if (rise[i])
          edge_lat[i] <= 1'b1;
        else if (ack_pulse[i])
          edge_lat[i] <= 1'b0;
      end
    end
  end

  assign pad_wic_int_vld = (int_edge_mode & edge_lat) | (~int_edge_mode & filt_q);
  assign int_src_stat    = filt_q;

endmodule

// File: tb/tb_wic_int_cond.sv
// Scoreboard bench for wic_int_cond: stimulus schedules expected outputs at absolute edge
// numbers; a negedge monitor compares and retires them.
module tb_wic_int_cond;

  logic        wic_clk = 1'b0;
  logic        pad_cpu_rst_b;
  logic [31:0] pad_int_src;
  logic [31:0] int_edge_mode;
  logic [31:0] int_filt_en;
  logic [3:0]  filt_cyc;
  logic [31:0] biu_pad_psr;
  logic [31:0] pad_wic_int_vld;
  logic [31:0] int_src_stat;

  wic_int_cond #(.FILT_W(4)) dut (
    .wic_clk         (wic_clk),
    .pad_cpu_rst_b   (pad_cpu_rst_b),
    .pad_int_src     (pad_int_src),
    .int_edge_mode   (int_edge_mode),
    .int_filt_en     (int_filt_en),
    .filt_cyc        (filt_cyc),
    .biu_pad_psr     (biu_pad_psr),
    .pad_wic_int_vld (pad_wic_int_vld),
    .int_src_stat    (int_src_stat)
  );

  always #5 wic_clk = ~wic_clk;

  typedef struct {
    int          at;
    string       name;
    logic [31:0] vmask;
    logic [31:0] vexp;
    logic [31:0] smask;
    logic [31:0] sexp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge wic_clk) cyc <= cyc + 1;

  // Retire every expectation due after the edge just counted
  always @(negedge wic_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        tests++;
        if (((pad_wic_int_vld & sb[i].vmask) != (sb[i].vexp & sb[i].vmask)) ||
            ((int_src_stat & sb[i].smask) != (sb[i].sexp & sb[i].smask))) begin
          fails++;
          $display("FAIL %s @edge %0d: vld=%h stat=%h required vld=%h/%h stat=%h/%h",
                   sb[i].name, cyc, pad_wic_int_vld, int_src_stat,
                   sb[i].vexp, sb[i].vmask, sb[i].sexp, sb[i].smask);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int at, input string nm, input logic [31:0] vm,
                           input logic [31:0] ve, input logic [31:0] sm, input logic [31:0] se);
    exp_t e;
    e.at = at; e.name = nm; e.vmask = vm; e.vexp = ve; e.smask = sm; e.sexp = se;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge wic_clk);
    #1;
  endtask

  function automatic logic [31:0] vec(input int v);
    logic [4:0] n;
    n = v[4:0];
    return {8'h0, 3'b001, n, 16'h0};
  endfunction

  int c;
  int guard;

  initial begin
    pad_cpu_rst_b = 1'b0;
    pad_int_src   = '1;
    int_edge_mode = '0;
    int_filt_en   = '0;
    filt_cyc      = 4'd0;
    biu_pad_psr   = '0;

    // Reset with all inputs high, then release
    step(2);
    tests++;
    if (pad_wic_int_vld !== 32'h0 || int_src_stat !== 32'h0) begin
      fails++;
      $display("FAIL in_reset: vld=%h stat=%h", pad_wic_int_vld, int_src_stat);
    end
    expect_at(cyc + 1, "reset_outputs", '1, '0, '1, '0);
    step(1);
    pad_cpu_rst_b = 1'b1;
    c = cyc;
    expect_at(c + 2, "reset_rel_e2", '1, '0, '1, '0);
    expect_at(c + 3, "reset_rel_e3", '1, '1, '1, '1);
    step(4);
    tests++;
    if (pad_wic_int_vld !== 32'hFFFFFFFF) begin
      fails++;
      $display("FAIL reset_rel_all: vld=%h", pad_wic_int_vld);
    end

    // Level, filter off, line 5
    pad_int_src = '0;
    step(5);
    pad_int_src[5] = 1'b1;
    c = cyc;
    expect_at(c + 2, "lvl5_rise_e2", '1, '0, '1, '0);
    expect_at(c + 3, "lvl5_rise_e3", '1, 32'h20, '1, 32'h20);
    step(5);
    tests++;
    if (pad_wic_int_vld[5] !== 1'b1) begin
      fails++;
      $display("FAIL lvl5_high: vld=%h", pad_wic_int_vld);
    end
    pad_int_src[5] = 1'b0;
    c = cyc;
    expect_at(c + 2, "lvl5_fall_e2", 32'h20, 32'h20, 32'h20, 32'h20);
    expect_at(c + 3, "lvl5_fall_e3", 32'h20, 32'h0, 32'h20, 32'h0);
    step(5);
    tests++;
    if (pad_wic_int_vld[5] !== 1'b0) begin
      fails++;
      $display("FAIL lvl5_low: vld=%h", pad_wic_int_vld);
    end

    // Glitch filter on line 7, threshold 4: two 3-cycle glitches then a 6-cycle pulse
    int_filt_en[7] = 1'b1;
    filt_cyc       = 4'd4;
    for (int g = 0; g < 2; g++) begin
      pad_int_src[7] = 1'b1;
      c = cyc;
      step(3);
      pad_int_src[7] = 1'b0;
      expect_at(c + 6, "glitch7_mid", 32'h80, 32'h0, 32'h80, 32'h0);
      expect_at(c + 8, "glitch7_end", 32'h80, 32'h0, 32'h80, 32'h0);
      step(7);
    end
    pad_int_src[7] = 1'b1;
    c = cyc;
    expect_at(c + 5, "filt7_rise_e5", 32'h80, 32'h0, 32'h80, 32'h0);
    expect_at(c + 6, "filt7_rise_e6", 32'h80, 32'h80, 32'h80, 32'h80);
    step(6);
    pad_int_src[7] = 1'b0;
    c = cyc;
    expect_at(c + 5, "filt7_fall_e5", 32'h80, 32'h80, 32'h80, 32'h80);
    expect_at(c + 6, "filt7_fall_e6", 32'h80, 32'h0, 32'h80, 32'h0);
    step(8);

    // filt_cyc=0 acts as threshold 1: a single-cycle pulse passes
    filt_cyc = 4'd0;
    pad_int_src[7] = 1'b1;
    c = cyc;
    step(1);
    pad_int_src[7] = 1'b0;
    expect_at(c + 3, "thr0_pulse_e3", 32'h80, 32'h80, 32'h80, 32'h80);
    expect_at(c + 4, "thr0_pulse_e4", 32'h80, 32'h0, 32'h80, 32'h0);
    step(6);
    int_filt_en = '0;

    // Edge mode with acknowledge, line 10
    int_edge_mode[10] = 1'b1;
    step(1);
    pad_int_src[10] = 1'b1;
    c = cyc;
    expect_at(c + 2, "edge10_e2", 32'h400, 32'h0, 32'h400, 32'h0);
    expect_at(c + 3, "edge10_set", 32'h400, 32'h400, 32'h400, 32'h400);
    expect_at(c + 8, "edge10_held", 32'h400, 32'h400, 32'h400, 32'h0);
    step(2);
    pad_int_src[10] = 1'b0;
    step(7);
    biu_pad_psr = vec(10);
    c = cyc;
    expect_at(c + 1, "edge10_ack", 32'h400, 32'h0, 32'h400, 32'h0);
    step(2);
    tests++;
    if (pad_wic_int_vld[10] !== 1'b0) begin
      fails++;
      $display("FAIL edge10_cleared: vld=%h", pad_wic_int_vld);
    end
    pad_int_src[10] = 1'b1;
    c = cyc;
    expect_at(c + 3, "edge10_reset", 32'h400, 32'h400, 32'h400, 32'h400);
    expect_at(c + 10, "edge10_psr_hold", 32'h400, 32'h400, 32'h400, 32'h400);
    step(11);
    pad_int_src[10] = 1'b0;
    biu_pad_psr = '0;
    int_edge_mode[10] = 1'b0;
    step(5);

    // Rise event on line 12 coincident with ack_pulse[12]; then an ack for 13
    int_edge_mode[12] = 1'b1;
    step(1);
    pad_int_src[12] = 1'b1;
    c = cyc;
    step(2);
    biu_pad_psr = vec(12);
    expect_at(c + 3, "sim12_set_wins", 32'h1000, 32'h1000, 32'h1000, 32'h1000);
    expect_at(c + 5, "sim12_stays", 32'h1000, 32'h1000, 32'h1000, 32'h1000);
    step(4);
    biu_pad_psr = vec(13);
    c = cyc;
    expect_at(c + 1, "ack13_no_effect_e1", 32'h1000, 32'h1000, '0, '0);
    expect_at(c + 3, "ack13_no_effect_e3", 32'h1000, 32'h1000, '0, '0);
    step(4);
    biu_pad_psr = '0;
    pad_int_src[12] = 1'b0;
    int_edge_mode[12] = 1'b0;
    step(5);

    // Mode switch on line 3 clears the latch
    int_edge_mode[3] = 1'b1;
    step(1);
    pad_int_src[3] = 1'b1;
    c = cyc;
    step(2);
    pad_int_src[3] = 1'b0;
    expect_at(c + 8, "edge3_latched", 32'h8, 32'h8, 32'h8, 32'h0);
    step(8);
    int_edge_mode[3] = 1'b0;
    c = cyc;
    expect_at(c + 1, "mode3_level", 32'h8, 32'h0, 32'h8, 32'h0);
    step(2);
    int_edge_mode[3] = 1'b1;
    c = cyc;
    expect_at(c + 1, "edge3_lat_clear", 32'h8, 32'h0, 32'h8, 32'h0);
    step(2);
    int_edge_mode[3] = 1'b0;

    // Level-mode line 4 ignores an ack for vector 4
    pad_int_src[4] = 1'b1;
    step(4);
    biu_pad_psr = vec(4);
    c = cyc;
    expect_at(c + 1, "lvl4_ack_e1", 32'h10, 32'h10, 32'h10, 32'h10);
    expect_at(c + 3, "lvl4_ack_e3", 32'h10, 32'h10, 32'h10, 32'h10);
    step(4);
    tests++;
    if (pad_wic_int_vld[4] !== 1'b1) begin
      fails++;
      $display("FAIL lvl4_ack_ignored: vld=%h", pad_wic_int_vld);
    end
    biu_pad_psr = '0;
    pad_int_src[4] = 1'b0;

    // Drain the scoreboard with a bound
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      step(1);
      guard++;
    end
    foreach (sb[i]) begin
      tests++;
      fails++;
      $display("FAIL %s: never checked (due edge %0d, now %0d)", sb[i].name, sb[i].at, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
